// File: rtl/reg_snapshot_dumper.sv
// Cycle-triggered register-file snapshot: stall CPU, capture, stream out.
// Ports: clk_i/rst_i, cfg_*, rf_addr_o/rf_data_i, hold_o, dump_*, done_o, cycle_cnt_o.
module reg_snapshot_dumper #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 13,
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [CNT_W-1:0]  cfg_end_count_i,
  input  logic              cfg_periodic_i,
  output logic [ADDR_W-1:0] rf_addr_o,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic              hold_o,
  output logic              dump_valid_o,
  input  logic              dump_ready_i,
  output logic [ADDR_W-1:0] dump_idx_o,
  output logic [DATA_W-1:0] dump_data_o,
  output logic              dump_last_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  cycle_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN,
    S_CAPTURE,
    S_DRAIN,
    S_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  CMAX = '1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              per_q, per_d;

  // Sized to the full address space so any ADDR_W index is in range.
  logic [DATA_W-1:0] buf_q [2**ADDR_W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    per_d   = per_q;
    unique case (state_q)
      S_RUN: begin
        if (cfg_end_count_i != '0 &&
            cnt_q == cfg_end_count_i) begin
          // Counter holds on the trigger edge.
          state_d = S_CAPTURE;
          addr_d  = '0;
          per_d   = cfg_periodic_i;
        end else if (cnt_q != CMAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_CAPTURE: begin
        if (addr_q == LAST) begin
          state_d = S_DRAIN;
          addr_d  = '0;
          idx_d   = '0;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (dump_ready_i) begin
          if (idx_q == LAST) begin
            idx_d = '0;
            if (per_q) begin
              state_d = S_RUN;
              cnt_d   = '0;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      per_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      per_q   <= per_d;
    end
  end

  // Buffer contents are don't-care after reset.
  always_ff @(posedge clk_i) begin
    if (state_q == S_CAPTURE) begin
      buf_q[addr_q] <= rf_data_i;
    end
  end

  assign hold_o       = (state_q == S_CAPTURE);
  assign dump_valid_o = (state_q == S_DRAIN);
  assign dump_idx_o   = idx_q;
  // Gated so stale or unwritten buffer never leaks out.
  assign dump_data_o  = dump_valid_o ? buf_q[idx_q] : '0;
  assign dump_last_o  = dump_valid_o && (idx_q == LAST);
  assign done_o       = (state_q == S_DONE);
  assign cycle_cnt_o  = cnt_q;
  assign rf_addr_o    = addr_q;

endmodule

// File: tb/tb_reg_snapshot_dumper.sv
// Scoreboard bench for reg_snapshot_dumper with a cycle-indexed RF model.
// Ports: drives all DUT inputs, monitors all outputs.
module tb_reg_snapshot_dumper;
  localparam int DW = 32;
  localparam int NR = 13;
  localparam int AW = 5;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic [CW-1:0] cfg_end = '0;
  logic          cfg_per = 1'b0;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          hold, valid, last, done;
  logic          ready = 1'b1;
  logic [AW-1:0] idx;
  logic [DW-1:0] data;
  logic [CW-1:0] cnt;

  int          cyc = 0;
  int          rf_mode = 0;
  logic [31:0] seed = 32'h1234_5678;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [AW-1:0] idx;
    logic [DW-1:0] data;
    logic          last;
  } word_t;
  word_t expq[$];

  int xfers = 0, hold_cnt = 0, valid_cnt = 0;
  int first_hold = -1, first_valid = -1;
  bit done_seen = 0;
  int rdy_mode = 0;

  reg_snapshot_dumper #(
    .DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .cfg_end_count_i(cfg_end),
    .cfg_periodic_i(cfg_per),
    .rf_addr_o(rf_addr),
    .rf_data_i(rf_data),
    .hold_o(hold),
    .dump_valid_o(valid),
    .dump_ready_i(ready),
    .dump_idx_o(idx),
    .dump_data_o(data),
    .dump_last_o(last),
    .done_o(done),
    .cycle_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  // cyc equals the index of the next rising edge.
  always @(posedge clk) begin
    #1;
    cyc++;
  end

  function automatic logic [DW-1:0] rf_val(
    int m, logic [31:0] s, logic [AW-1:0] a, int c);
    if (m == 0) return DW'(100) + DW'(a);
    if (m == 1) return DW'(a) ^ DW'(c);
    return s ^ (DW'(a) * 32'h9E3779B1)
             ^ (DW'(c) * 32'h85EBCA6B);
  endfunction

  assign rf_data = rf_val(rf_mode, seed, rf_addr, cyc);

  task automatic chk(string n, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", n, act, exp);
    end
  endtask

  // Ready driver.
  int stall_left = 0;
  int stalled_idx = -1;
  always @(posedge clk) begin
    #2;
    if (rdy_mode == 1) begin
      ready = ($urandom_range(0, 2) != 0);
    end else if (rdy_mode == 2) begin
      if (stall_left > 0) begin
        ready = 1'b0;
        stall_left--;
      end else if (valid && idx[0] &&
                   int'(idx) != stalled_idx) begin
        ready = 1'b0;
        stall_left = 2;
        stalled_idx = int'(idx);
      end else begin
        ready = 1'b1;
        if (!valid) stalled_idx = -1;
      end
    end else begin
      ready = 1'b1;
    end
  end

  // Monitor.
  bit            pstall = 0, phold = 0, pvalid = 0;
  logic [AW-1:0] pidx;
  logic [DW-1:0] pdata;
  always @(negedge clk) begin
    if (!rst_i) begin
      pstall = 0;
      phold  = 0;
      pvalid = 0;
    end else begin
      if (hold) hold_cnt++;
      if (hold && !phold) first_hold = cyc;
      if (valid && !pvalid) first_valid = cyc;
      if (valid) valid_cnt++;
      if (done) done_seen = 1;
      if (pstall) begin
        chk("stall_valid", valid, 1);
        chk("stall_idx", idx, pidx);
        chk("stall_data", data, pdata);
      end
      if (valid && ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=idx%0d required=none",
                   idx);
        end else begin
          word_t w;
          w = expq.pop_front();
          chk("word_idx", idx, w.idx);
          chk("word_data", data, w.data);
          chk("word_last", last, w.last);
        end
        xfers++;
      end
      pstall = valid && !ready;
      pidx   = idx;
      pdata  = data;
      phold  = hold;
      pvalid = valid;
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_hold"}, hold, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_last"}, last, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_idx"}, idx, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_cnt"}, cnt, 0);
    chk({tag, "_addr"}, rf_addr, 0);
  endtask

  task automatic start(int cv, bit per, int mode, output int c0);
    rst_i   = 1'b0;
    cfg_end = CW'(cv);
    cfg_per = per;
    rf_mode = mode;
    seed    = $urandom;
    tick(2);
    chk_zero("rst");
    expq.delete();
    xfers = 0;
    hold_cnt = 0;
    valid_cnt = 0;
    done_seen = 0;
    first_hold = -1;
    first_valid = -1;
    rst_i = 1'b1;
    c0 = cyc;
  endtask

  // Reg i is sampled on edge t+1+i where t is the trigger edge.
  task automatic push_dump(int t);
    for (int i = 0; i < NR; i++) begin
      word_t w;
      w.idx  = AW'(i);
      w.data = rf_val(rf_mode, seed, AW'(i), t + 1 + i);
      w.last = (i == NR - 1);
      expq.push_back(w);
    end
  endtask

  task automatic wait_xfers(int n, int budget, string name);
    int k = 0;
    while (xfers < n && k < budget) begin
      tick(1);
      k++;
    end
    chk({name, "_xfers"}, xfers, n);
  endtask

  initial begin
    int c0, t, cv, per;

    // Baseline one-shot.
    start(25, 0, 0, c0);
    t = c0 + 25;
    push_dump(t);
    wait_xfers(NR, 200, "base");
    tick(1);
    chk("base_hold_cnt", hold_cnt, NR);
    chk("base_hold_start", first_hold, t + 1);
    chk("base_latency", first_valid, t + NR + 1);
    chk("base_done", done, 1);
    chk("base_cnt", cnt, 25);
    chk("base_q_empty", expq.size(), 0);
    cfg_end = 3;
    tick(20);
    chk("done_cnt", cnt, 25);
    chk("done_sticky", done, 1);
    chk("done_valid_cnt", valid_cnt, NR);
    chk("done_hold_cnt", hold_cnt, NR);

    // Backpressure: odd words stall 3 cycles.
    rdy_mode = 2;
    start(25, 0, 2, c0);
    push_dump(c0 + 25);
    wait_xfers(NR, 400, "bp");
    tick(1);
    chk("bp_done", done, 1);
    chk("bp_valid_cycles", valid_cnt, NR + 6 * 3);
    chk("bp_q_empty", expq.size(), 0);
    rdy_mode = 0;

    // Random trigger and random ready.
    for (int r = 0; r < 3; r++) begin
      rdy_mode = 1;
      cv = $urandom_range(3, 40);
      start(cv, 0, 2, c0);
      push_dump(c0 + cv);
      wait_xfers(NR, 600, "rnd");
      tick(1);
      chk("rnd_done", done, 1);
      chk("rnd_cnt", cnt, cv);
      chk("rnd_hold_cnt", hold_cnt, NR);
      chk("rnd_hold_start", first_hold, c0 + cv + 1);
    end
    rdy_mode = 0;

    // Periodic, three dumps back to back.
    start(10, 1, 1, c0);
    per = 2 * NR + 1 + 10;
    for (int k = 0; k < 3; k++) push_dump(c0 + 10 + k * per);
    wait_xfers(3 * NR, 300, "per");
    chk("per_hold_cnt", hold_cnt, 3 * NR);
    chk("per_no_done", done_seen, 0);
    chk("per_rearm_cnt", cnt, 0);
    chk("per_q_empty", expq.size(), 0);

    // Config change during capture.
    start(25, 1, 2, c0);
    t = c0 + 25;
    push_dump(t);
    tick(29);
    chk("mid_in_capture", hold, 1);
    cfg_end = 5;
    push_dump(t + 2 * NR + 1 + 5);
    wait_xfers(2 * NR, 300, "mid");
    chk("mid_hold_cnt", hold_cnt, 2 * NR);
    chk("mid_no_done", done_seen, 0);
    chk("mid_q_empty", expq.size(), 0);

    // Reset abort on sixth drain word.
    start(20, 0, 2, c0);
    push_dump(c0 + 20);
    begin
      int k = 0;
      while (!(valid && idx == 5) && k < 100) begin
        tick(1);
        k++;
      end
    end
    chk("abort_reached", valid && idx == 5, 1);
    rst_i = 1'b0;
    #1;
    chk_zero("abort");
    chk("abort_xfers", xfers, 5);
    start(8, 0, 2, c0);
    chk("restart_cnt0", cnt, 0);
    tick(4);
    chk("restart_cnt4", cnt, 4);
    push_dump(c0 + 8);
    wait_xfers(NR, 200, "restart");
    tick(1);
    chk("restart_done", done, 1);
    chk("restart_q_empty", expq.size(), 0);

    // Disabled trigger and counter saturation.
    start(0, 0, 0, c0);
    tick(65540);
    chk("sat_cnt", cnt, 65535);
    chk("sat_hold_cnt", hold_cnt, 0);
    chk("sat_valid_cnt", valid_cnt, 0);
    cfg_end = 1000;
    tick(30);
    chk("passed_hold_cnt", hold_cnt, 0);
    chk("passed_valid_cnt", valid_cnt, 0);
    chk("passed_cnt", cnt, 65535);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_snapshot_dumper.md
Name: reg_snapshot_dumper

Overview:
- Synthesizable, parametrised successor to the fixed end-of-run register print.
- Counts CPU clock cycles from reset release, then captures a programmable number of register-file entries at a programmable cycle count.
- Stalls the CPU while it captures, then streams the snapshot out over a valid/ready interface.
- Supports one-shot or periodic snapshots; sits beside Simple_Single_CPU's register file on a dedicated debug read port.

Parameters:
- DATA_W, 32, register data width
- NUM_REGS, 13, registers captured per snapshot (indices 0..NUM_REGS-1); range 1..2**ADDR_W
- ADDR_W, 5, register-file address width
- CNT_W, 16, cycle counter width

Ports:
- clk_i  in  1  system clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- cfg_end_count_i  in  CNT_W  trigger cycle count; 0 disables triggering
- cfg_periodic_i  in  1  1 = re-arm after each dump; 0 = one-shot
- rf_addr_o  out  ADDR_W  debug read address into register file
- rf_data_i  in  DATA_W  combinational read data for rf_addr_o
- hold_o  out  1  CPU stall request (freeze PC and RF writes)
- dump_valid_o  out  1  snapshot word valid
- dump_ready_i  in  1  consumer ready
- dump_idx_o  out  ADDR_W  register index of current word
- dump_data_o  out  DATA_W  register value of current word
- dump_last_o  out  1  marks word NUM_REGS-1
- done_o  out  1  one-shot dump complete
- cycle_cnt_o  out  CNT_W  current cycle count

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=RUN.
  - cycle_cnt_o=0, rf_addr_o=0.
  - hold_o, dump_valid_o, dump_last_o and done_o all 0.
  - dump_idx_o=0, dump_data_o=0.
  - Snapshot buffer contents are don't-care.
- Counter:
  - Increments by 1 on every rising edge while state=RUN.
  - Holds in CAPTURE, DRAIN and DONE.
  - Saturates at 2**CNT_W-1; never wraps.
- RUN:
  - If cfg_end_count_i != 0 and cycle_cnt_o == cfg_end_count_i at a rising edge: go to CAPTURE, set hold_o=1, set rf_addr_o=0.
  - A trigger value that the counter has already passed, or that exceeds the saturation value, never fires.
- CAPTURE (exactly NUM_REGS cycles):
  - Each cycle, rf_data_i is sampled into buffer[rf_addr_o], then rf_addr_o increments.
  - After index NUM_REGS-1 is sampled: hold_o=0, go to DRAIN with word 0 presented.
  - hold_o is high for exactly NUM_REGS cycles.
- DRAIN:
  - dump_valid_o=1.
  - dump_idx_o and dump_data_o=buffer[dump_idx_o] are held stable while dump_ready_i=0.
  - A word transfers on a rising edge with valid&ready; the index then advances.
  - dump_last_o=1 iff dump_idx_o==NUM_REGS-1.
  - Ready may toggle arbitrarily; no word is dropped or duplicated.
  - Transfer of the last word in one-shot mode: dump_valid_o=0, done_o=1, go to DONE.
  - Transfer of the last word in periodic mode: dump_valid_o=0, cycle_cnt_o=0, go to RUN (re-armed).
- DONE:
  - Terminal; done_o stays 1 until reset.
  - Counter frozen; config changes are ignored.
- Config:
  - cfg_* are sampled only in RUN.
  - Changes during CAPTURE or DRAIN do not affect the snapshot in progress.
- Reset mid-CAPTURE or mid-DRAIN:
  - Immediate abort; hold_o and dump_valid_o drop asynchronously.
  - The partial snapshot is discarded and is never emitted after reset release.
- NUM_REGS=1:
  - CAPTURE lasts 1 cycle.
  - dump_last_o is high on the only word.
- Latency: trigger edge to first dump_valid_o = NUM_REGS+1 edges (trigger edge plus NUM_REGS capture edges).

Test Plan:
- Baseline one-shot: NUM_REGS=13, cfg_end_count_i=25, cfg_periodic_i=0, RF model returns 100+addr, dump_ready_i=1 → hold_o high for exactly 13 cycles starting after the edge where cycle_cnt_o=25; 13 words stream with idx 0..12 and data 100..112; dump_last_o only on idx 12; done_o=1; cycle_cnt_o stays at 25.
- Backpressure: same setup with dump_ready_i low for 3 cycles every other word → each word's idx/data stable while stalled; exactly 13 transfers, in order, no repeats.
- Periodic: cfg_end_count_i=10, cfg_periodic_i=1, RF model = addr XOR cycle-of-sample → three consecutive dumps, each preceded by 10 RUN cycles and reflecting RF values at its own capture window; done_o never asserts.
- Disabled and saturation: cfg_end_count_i=0 for 70000 cycles with CNT_W=16 → no hold_o, no dump_valid_o, cycle_cnt_o saturates at 65535.
- Reset abort: assert rst_i low on the 6th DRAIN word → all outputs 0 asynchronously; after release, cycle_cnt_o restarts at 0 and the next dump starts at idx 0 with fresh data.
- Mid-dump config change: change cfg_end_count_i from 25 to 5 during CAPTURE → current snapshot unaffected; in periodic mode the next trigger fires at 5.
